// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer.
// FSM states, key-mode codes and round counts.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] KM_128  = 2'b00;
    localparam logic [1:0] KM_192  = 2'b01;
    localparam logic [1:0] KM_256  = 2'b10;
    localparam logic [1:0] KM_RSVD = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        logic [3:0] nr;
        case (mode)
            KM_192:  nr = NR_192;
            KM_256:  nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

    function automatic logic mode_ok(input logic [1:0] mode,
                                     input logic       wide);
        return (mode == KM_128) ||
               (wide && (mode == KM_192 || mode == KM_256));
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Request/control bundle between the sequencer and its user.
// i_* flow into the sequencer, o_* flow out.
interface aes_round_sequencer_if #(parameter int RND_W = 4);
    logic             i_valid;
    logic [1:0]       i_key_mode;
    logic             i_stall;
    logic             i_abort;
    logic             i_ready;
    logic             o_ready;
    logic             o_busy;
    logic             o_dp_en;
    logic [RND_W-1:0] o_round;
    logic             o_first;
    logic             o_last;
    logic [1:0]       o_mode;
    logic             o_valid;
    logic             o_err;

    modport slave (
        input  i_valid, i_key_mode, i_stall, i_abort, i_ready,
        output o_ready, o_busy, o_dp_en, o_round, o_first,
        output o_last, o_mode, o_valid, o_err
    );

    modport master (
        output i_valid, i_key_mode, i_stall, i_abort, i_ready,
        input  o_ready, o_busy, o_dp_en, o_round, o_first,
        input  o_last, o_mode, o_valid, o_err
    );
endinterface

// File: rtl/aes_round_counter.sv
// Round index counter: clear to zero, step on enable,
// flag when the next step reaches the round count.
module aes_round_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] nr_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + W'(1);
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == nr_i - W'(1));

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: walks INIT, ROUND..., FINAL, DONE
// for one block, with stall, abort and result handshake.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int RND_W        = 4,
    parameter bit EN_WIDE_KEYS = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    aes_round_sequencer_if.slave bus
);

    state_e           state_q;
    logic [1:0]       mode_q;
    logic             err_q;
    logic [RND_W-1:0] cnt;
    logic [RND_W-1:0] nr;
    logic             term;
    logic             active;
    logic             cnt_clr;
    logic             cnt_en;

    assign nr     = RND_W'(nr_of(mode_q));
    assign active = (state_q == ST_INIT)  ||
                    (state_q == ST_ROUND) ||
                    (state_q == ST_FINAL);

    // FINAL holds the count at Nr; IDLE/DONE/abort zero it.
    assign cnt_clr = (state_q == ST_IDLE) ||
                     (state_q == ST_DONE) ||
                     (active && bus.i_abort);
    assign cnt_en  = ((state_q == ST_INIT) ||
                      (state_q == ST_ROUND)) && !bus.i_stall;

    aes_round_counter #(.W(RND_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .nr_i   (nr),
        .cnt_o  (cnt),
        .term_o (term)
    );

    // Block FSM; abort beats stall and the result handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= KM_128;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        if (mode_ok(bus.i_key_mode, EN_WIDE_KEYS)) begin
                            mode_q  <= bus.i_key_mode;
                            state_q <= ST_INIT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    if (bus.i_abort)
                        state_q <= ST_IDLE;
                    else if (!bus.i_stall)
                        state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (bus.i_abort)
                        state_q <= ST_IDLE;
                    else if (!bus.i_stall && term)
                        state_q <= ST_FINAL;
                end
                ST_FINAL: begin
                    if (bus.i_abort)
                        state_q <= ST_IDLE;
                    else if (!bus.i_stall)
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.i_abort || bus.i_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_busy  = active;
    assign bus.o_dp_en = active && !bus.i_stall;
    assign bus.o_round = active ? cnt : '0;
    assign bus.o_first = (state_q == ST_INIT);
    assign bus.o_last  = (state_q == ST_FINAL);
    assign bus.o_valid = (state_q == ST_DONE);
    assign bus.o_mode  = mode_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with
// hand-computed cycle-by-cycle expectations.
module tb_aes_round_sequencer;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    int   t0;
    int   n;
    logic seen_valid;

    aes_round_sequencer_if #(.RND_W(4)) bus ();

    aes_round_sequencer #(
        .RND_W        (4),
        .EN_WIDE_KEYS (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] mode);
        chk({tag, "_ready"}, 32'(bus.o_ready), 1);
        chk({tag, "_busy"},  32'(bus.o_busy),  0);
        chk({tag, "_dpen"},  32'(bus.o_dp_en), 0);
        chk({tag, "_round"}, 32'(bus.o_round), 0);
        chk({tag, "_first"}, 32'(bus.o_first), 0);
        chk({tag, "_last"},  32'(bus.o_last),  0);
        chk({tag, "_valid"}, 32'(bus.o_valid), 0);
        chk({tag, "_err"},   32'(bus.o_err),   0);
        chk({tag, "_mode"},  32'(bus.o_mode),  32'(mode));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_key_mode = 2'b00;
        bus.i_stall    = 1'b0;
        bus.i_abort    = 1'b0;
        bus.i_ready    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk_idle("reset", 2'b00);

        // AES-128, no stalls
        bus.i_valid = 1'b1;
        bus.i_key_mode = 2'b00;
        #1;
        chk("a128_acc_ready", 32'(bus.o_ready), 1);
        t0 = cyc;
        tick();
        bus.i_valid = 1'b0;
        #1;
        chk("a128_init_round", 32'(bus.o_round), 0);
        chk("a128_init_first", 32'(bus.o_first), 1);
        chk("a128_init_busy",  32'(bus.o_busy),  1);
        chk("a128_init_dpen",  32'(bus.o_dp_en), 1);
        chk("a128_init_ready", 32'(bus.o_ready), 0);
        for (int r = 1; r <= 9; r++) begin
            tick();
            #1;
            chk("a128_round", 32'(bus.o_round), 32'(r));
            chk("a128_rnd_last", 32'(bus.o_last), 0);
            chk("a128_rnd_first", 32'(bus.o_first), 0);
        end
        tick();
        #1;
        chk("a128_final_round", 32'(bus.o_round), 10);
        chk("a128_final_last",  32'(bus.o_last),  1);
        chk("a128_final_time",  32'(cyc - t0),    11);
        tick();
        #1;
        chk("a128_done_valid", 32'(bus.o_valid), 1);
        chk("a128_done_time",  32'(cyc - t0),    12);
        chk("a128_done_round", 32'(bus.o_round), 0);
        chk("a128_done_busy",  32'(bus.o_busy),  0);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        #1;
        chk("a128_idle_ready", 32'(bus.o_ready), 1);
        chk("a128_idle_valid", 32'(bus.o_valid), 0);
        chk("a128_idle_time",  32'(cyc - t0),    13);

        // AES-256, 3 stall cycles at round 5
        bus.i_valid = 1'b1;
        bus.i_key_mode = 2'b10;
        t0 = cyc;
        tick();
        bus.i_valid = 1'b0;
        #1;
        chk("a256_mode", 32'(bus.o_mode), 2);
        repeat (5) tick();
        #1;
        chk("a256_round5", 32'(bus.o_round), 5);
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("a256_stall_round", 32'(bus.o_round), 5);
            chk("a256_stall_dpen",  32'(bus.o_dp_en), 0);
            chk("a256_stall_busy",  32'(bus.o_busy),  1);
            tick();
        end
        bus.i_stall = 1'b0;
        #1;
        chk("a256_resume_round", 32'(bus.o_round), 5);
        chk("a256_resume_dpen",  32'(bus.o_dp_en), 1);
        n = 0;
        while (!bus.o_valid && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk("a256_valid",      32'(bus.o_valid), 1);
        chk("a256_valid_time", 32'(cyc - t0),    19);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        #1;

        // Reserved mode rejected
        bus.i_valid = 1'b1;
        bus.i_key_mode = 2'b11;
        #1;
        chk("rsvd_ready", 32'(bus.o_ready), 1);
        tick();
        bus.i_valid = 1'b0;
        #1;
        chk("rsvd_err",   32'(bus.o_err),   1);
        chk("rsvd_busy",  32'(bus.o_busy),  0);
        chk("rsvd_ready2", 32'(bus.o_ready), 1);
        chk("rsvd_mode",  32'(bus.o_mode),  2);
        tick();
        #1;
        chk("rsvd_err_off", 32'(bus.o_err),  0);
        chk("rsvd_busy2",   32'(bus.o_busy), 0);

        // AES-192, abort with stall at round 7 (abort in IDLE ignored)
        bus.i_valid = 1'b1;
        bus.i_key_mode = 2'b01;
        bus.i_abort = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        bus.i_abort = 1'b0;
        #1;
        chk("a192_first", 32'(bus.o_first), 1);
        chk("a192_mode",  32'(bus.o_mode),  1);
        repeat (7) tick();
        #1;
        chk("a192_round7", 32'(bus.o_round), 7);
        bus.i_stall = 1'b1;
        bus.i_abort = 1'b1;
        #1;
        chk("a192_abort_dpen", 32'(bus.o_dp_en), 0);
        tick();
        bus.i_stall = 1'b0;
        bus.i_abort = 1'b0;
        #1;
        chk("a192_abort_ready", 32'(bus.o_ready), 1);
        chk("a192_abort_busy",  32'(bus.o_busy),  0);
        chk("a192_abort_round", 32'(bus.o_round), 0);
        seen_valid = bus.o_valid;
        for (int k = 0; k < 16; k++) begin
            tick();
            #1;
            seen_valid = seen_valid | bus.o_valid;
        end
        chk("a192_no_valid", 32'(seen_valid), 0);

        // DONE held 4 cycles, new requests ignored
        bus.i_valid = 1'b1;
        bus.i_key_mode = 2'b00;
        tick();
        bus.i_valid = 1'b0;
        repeat (11) tick();
        bus.i_valid = 1'b1;
        bus.i_key_mode = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hold_valid", 32'(bus.o_valid), 1);
            chk("hold_ready", 32'(bus.o_ready), 0);
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        chk("hold_valid_last", 32'(bus.o_valid), 1);
        tick();
        bus.i_ready = 1'b0;
        #1;
        chk("hold_idle_ready", 32'(bus.o_ready), 1);
        chk("hold_idle_valid", 32'(bus.o_valid), 0);
        chk("hold_mode_kept",  32'(bus.o_mode),  0);

        // Reset in the middle of an AES-256 block
        bus.i_valid = 1'b1;
        bus.i_key_mode = 2'b10;
        tick();
        bus.i_valid = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_pre_round", 32'(bus.o_round), 3);
        rst_n = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_key_mode = 2'b01;
        tick();
        rst_n = 1'b1;
        bus.i_valid = 1'b0;
        #1;
        chk_idle("rst_mid", 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter RND_W, default 4, width of the round index output.
REQ-002 SHALL have parameter EN_WIDE_KEYS, default 1; when 1, AES-192 and AES-256 are supported; when 0, only AES-128 is supported.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 SHALL have port i_valid, input, 1 bit, block start request.
REQ-006 SHALL have port i_key_mode, input, 2 bits: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved.
REQ-007 SHALL have port i_stall, input, 1 bit, datapath/key-expansion not ready; freezes round progress.
REQ-008 SHALL have port i_abort, input, 1 bit, cancels the block in progress.
REQ-009 SHALL have port i_ready, input, 1 bit, downstream accepts the result.
REQ-010 SHALL have port o_ready, output, 1 bit, sequencer can accept a request.
REQ-011 SHALL have port o_busy, output, 1 bit, a block is in progress.
REQ-012 SHALL have port o_dp_en, output, 1 bit, datapath performs one round this cycle.
REQ-013 SHALL have port o_round, output, RND_W bits, index of the current round (0..Nr).
REQ-014 SHALL have port o_first, output, 1 bit, round 0 (AddRoundKey only).
REQ-015 SHALL have port o_last, output, 1 bit, round Nr (no MixColumns).
REQ-016 SHALL have port o_mode, output, 2 bits, key mode latched at accept.
REQ-017 SHALL have port o_valid, output, 1 bit, result available.
REQ-018 SHALL have port o_err, output, 1 bit, one-cycle pulse when an unsupported mode is rejected.

Function
REQ-019 SHALL implement states IDLE, INIT, ROUND, FINAL, DONE.
REQ-020 SHALL define Nr as 10, 12 or 14 for mode 00, 01 or 10 respectively, fixed from o_mode for the whole block.
REQ-021 SHALL accept a request only when i_valid and o_ready are both high in IDLE, latching i_key_mode into o_mode in that cycle.
REQ-022 SHALL reject an accepted request whose mode is 11, or whose mode is 01/10 when EN_WIDE_KEYS=0: o_err pulses for 1 cycle on the next cycle, the state stays IDLE, and o_mode is unchanged.
REQ-023 SHALL transition IDLE->INIT on a valid accept; in INIT: o_round=0, o_first=1.
REQ-024 SHALL transition INIT->ROUND with o_round=1; ROUND increments o_round each non-stalled cycle; ROUND->FINAL when o_round would reach Nr.
REQ-025 SHALL drive o_last=1 and o_round=Nr in FINAL, and transition FINAL->DONE.
REQ-026 SHALL assert o_dp_en in INIT, ROUND and FINAL only when i_stall=0; when stalled, the state and o_round hold and o_dp_en=0.
REQ-027 SHALL assert o_busy in INIT, ROUND and FINAL regardless of stall.
REQ-028 SHALL assert o_ready only in IDLE.
REQ-029 SHALL hold o_valid high in DONE until i_ready=1, then go DONE->IDLE on the next cycle.
REQ-030 SHALL give a latency with no stalls of accept at cycle T -> o_valid high at T+Nr+2 (AES-128: T+12); each stall cycle adds 1.
REQ-031 SHALL, when i_abort=1 in INIT, ROUND, FINAL or DONE, go to IDLE next cycle with o_valid never asserted for that block.
REQ-032 SHALL give i_abort priority over i_stall and over i_ready.
REQ-033 SHALL ignore i_abort in IDLE.
REQ-034 SHALL ignore i_valid outside IDLE; no request is queued.
REQ-035 SHALL drive o_round=0, o_first=0 and o_last=0 in IDLE and DONE.
REQ-036 SHALL decode all outputs except o_mode and o_err combinationally from state and counter.

Reset
REQ-037 SHALL, with rst_n=0 at a clk rising edge, force IDLE, o_round=0, o_mode=00 and o_err=0, regardless of other inputs, including mid-block.
REQ-038 SHALL, in the first cycle after reset release, present o_ready=1 and all other outputs at 0.

Structure
REQ-039 SHALL place the state encoding, key-mode codes and Nr constants (10/12/14) in shared package aes_pkg.
REQ-040 SHALL instantiate one sub-module, aes_round_counter (load-zero, enable-increment, terminal compare against Nr).

Verification
REQ-041 SHALL cover: AES-128 accept at T, no stalls -> o_round 0..10, o_last at T+11, o_valid at T+12, i_ready=1 -> IDLE at T+13.
REQ-042 SHALL cover: AES-256 with i_stall high for 3 cycles at round 5 -> o_round holds 5 and o_dp_en=0 for 3 cycles, o_valid at T+19.
REQ-043 SHALL cover: mode 11 request -> o_err one-cycle pulse, o_busy stays 0, o_ready stays 1.
REQ-044 SHALL cover: i_abort at round 7 of AES-192 with i_stall=1 -> IDLE next cycle, o_valid never asserted.
REQ-045 SHALL cover: i_ready held low for 4 cycles in DONE -> o_valid stays high for 4 cycles, new i_valid ignored until IDLE.
REQ-046 SHALL cover: rst_n low during ROUND -> IDLE with o_round=0, o_ready=1 on the cycle after release.
